ds_stream_mux: RTL and testbench

Parametrised N-channel, W-bit sample-stream selector for the delta-sigma datapath. It is the successor to the 2:1 gate-level mux. The output is registered, and channel switching happens only at frame boundaries. A programmable blanking interval inserts idle samples so that a partial frame is never spliced into the downstream decimator. Channel changes are requested through a valid/ready handshake from the control logic.

---
 rtl/ds_pkg.sv | 14 +
 rtl/ds_frame_counter.sv | 35 +++
 rtl/ds_stream_mux.sv | 122 ++++++++++++
 tb/tb_ds_stream_mux.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ds_pkg.sv
// Shared types for the delta-sigma stream selector and its frame counter.
package ds_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT_FRAME = 2'd1,
        BLANKING   = 2'd2
    } ds_state_t;

    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ds_frame_counter.sv
// Counts sample strobes 0..FRAME_LEN-1 and flags the strobe that closes a frame.
// Latency: wrap_o is combinational from in_valid_i; no backpressure.
module ds_frame_counter #(
    parameter int FRAME_LEN = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid_i,
    output logic [$clog2(FRAME_LEN)-1:0] frame_cnt_o,
    output logic                         wrap_o
);
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign frame_cnt_o = cnt_q;
    assign wrap_o      = in_valid_i && (cnt_q == LAST);

endmodule

// File: rtl/ds_stream_mux.sv
// N-channel registered sample selector; channel changes land only on frame wraps, followed by BLANK idle samples.
// Latency 1 clk on data; sel_req_ready is low while a switch is pending or blanking.
module ds_stream_mux
    import ds_pkg::*;
#(
    parameter int            N_CH      = 4,
    parameter int            W         = 1,
    parameter int            FRAME_LEN = 16,
    parameter int            BLANK     = 2,
    parameter logic [W-1:0]  IDLE_VAL  = '0,
    parameter int            INIT_SEL  = 0,
    localparam int           SELW      = sel_width(N_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH*W-1:0]   in_data,
    input  logic                in_valid,
    input  logic [SELW-1:0]     sel_req,
    input  logic                sel_req_valid,
    output logic                sel_req_ready,
    output logic [W-1:0]        out_data,
    output logic                out_valid,
    output logic [SELW-1:0]     cur_sel,
    output logic                switching,
    output logic                err
);
    localparam int              BCW        = (BLANK < 1) ? 1 : $clog2(BLANK + 1);
    localparam logic [BCW-1:0]  BLANK_LAST = BCW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [SELW:0]   NCH_V      = (SELW + 1)'(N_CH);

    ds_state_t          state_q, state_d;
    logic [SELW-1:0]    cur_sel_q, cur_sel_d;
    logic [SELW-1:0]    pend_sel_q, pend_sel_d;
    logic [BCW-1:0]     blank_cnt_q, blank_cnt_d;
    logic               err_q, err_d;
    logic [W-1:0]       out_data_q;
    logic               out_valid_q;
    logic               wrap;
    logic [$clog2(FRAME_LEN)-1:0] unused_frame_cnt;

    // Frame position is exported for the decimator; the mux only needs the wrap.
    ds_frame_counter #(.FRAME_LEN(FRAME_LEN)) u_frame_cnt (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .frame_cnt_o(unused_frame_cnt),
        .wrap_o     (wrap)
    );

    always_comb begin
        state_d       = state_q;
        cur_sel_d     = cur_sel_q;
        pend_sel_d    = pend_sel_q;
        blank_cnt_d   = blank_cnt_q;
        err_d         = err_q;
        sel_req_ready = (state_q == RUN);
        unique case (state_q)
            RUN: begin
                if (sel_req_valid) begin
                    if ({1'b0, sel_req} >= NCH_V) begin
                        err_d = 1'b1;
                    end else if (sel_req != cur_sel_q) begin
                        pend_sel_d = sel_req;
                        state_d    = WAIT_FRAME;
                    end
                end
            end
            WAIT_FRAME: begin
                if (wrap) begin
                    if (BLANK == 0) begin
                        cur_sel_d = pend_sel_q;
                        state_d   = RUN;
                    end else begin
                        blank_cnt_d = '0;
                        state_d     = BLANKING;
                    end
                end
            end
            BLANKING: begin
                if (in_valid) begin
                    if (blank_cnt_q == BLANK_LAST) begin
                        blank_cnt_d = '0;
                        cur_sel_d   = pend_sel_q;
                        state_d     = RUN;
                    end else begin
                        blank_cnt_d = blank_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            cur_sel_q   <= SELW'(INIT_SEL);
            pend_sel_q  <= SELW'(INIT_SEL);
            blank_cnt_q <= '0;
            err_q       <= 1'b0;
            out_data_q  <= IDLE_VAL;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_sel_q   <= cur_sel_d;
            pend_sel_q  <= pend_sel_d;
            blank_cnt_q <= blank_cnt_d;
            err_q       <= err_d;
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_data_q <= (state_q == BLANKING) ? IDLE_VAL : in_data[cur_sel_q*W +: W];
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign cur_sel   = cur_sel_q;
    assign switching = (state_q != RUN);
    assign err       = err_q;

endmodule

// File: tb/tb_ds_stream_mux.sv
// Directed bench: main instance N_CH=4/FRAME_LEN=8/BLANK=2, plus an N_CH=3 instance for out-of-range requests.
module tb_ds_stream_mux;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'b0101;   // ch0=1 ch1=0 ch2=1 ch3=0
    logic [2:0] in_data3 = 3'b101;   // ch0=1 ch1=0 ch2=1
    logic [1:0] sel_req = 2'd0;
    logic       sel_req_valid = 1'b0;
    logic       sel_req_ready;
    logic [0:0] out_data;
    logic       out_valid;
    logic [1:0] cur_sel;
    logic       switching;
    logic       err;
    logic [1:0] sel_req3 = 2'd0;
    logic       sel_req_valid3 = 1'b0;
    logic       sel_req_ready3;
    logic [0:0] out_data3;
    logic       out_valid3;
    logic [1:0] cur_sel3;
    logic       switching3;
    logic       err3;

    int pass_cnt = 0;
    int total_cnt = 0;
    int fc = 0;

    always #5 clk = ~clk;

    ds_stream_mux #(.N_CH(4), .W(1), .FRAME_LEN(8), .BLANK(2), .IDLE_VAL(1'b0), .INIT_SEL(0)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .sel_req(sel_req), .sel_req_valid(sel_req_valid), .sel_req_ready(sel_req_ready),
        .out_data(out_data), .out_valid(out_valid), .cur_sel(cur_sel),
        .switching(switching), .err(err)
    );

    ds_stream_mux #(.N_CH(3), .W(1), .FRAME_LEN(8), .BLANK(2), .IDLE_VAL(1'b0), .INIT_SEL(0)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid),
        .sel_req(sel_req3), .sel_req_valid(sel_req_valid3), .sel_req_ready(sel_req_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .cur_sel(cur_sel3),
        .switching(switching3), .err(err3)
    );

    // Advance one clock; outputs are examined 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (in_valid) fc = (fc + 1) % 8;
    endtask

    task automatic wait_fc(input int target);
        for (int n = 0; n < 16 && fc != target; n++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0;
        step(); step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 1'b0) $display("FAIL reset_out_data got=%b exp=0", out_data); else pass_cnt++;
        total_cnt++; if (cur_sel !== 2'd0) $display("FAIL reset_cur_sel got=%0d exp=0", cur_sel); else pass_cnt++;
        total_cnt++; if (sel_req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", sel_req_ready); else pass_cnt++;
        total_cnt++; if (err !== 1'b0 || err3 !== 1'b0) $display("FAIL reset_err got=%b/%b exp=0/0", err, err3); else pass_cnt++;
        total_cnt++; if (switching !== 1'b0) $display("FAIL reset_switching got=%b exp=0", switching); else pass_cnt++;
        rst = 1'b0; in_valid = 1'b1; fc = 0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL release_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        step();
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL first_out_valid got=%b exp=1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 1'b1) $display("FAIL first_out_data got=%b exp=1", out_data); else pass_cnt++;
    endtask

    task automatic test_noop_same_channel();
        sel_req = 2'd0; sel_req_valid = 1'b1;
        total_cnt++; if (sel_req_ready !== 1'b1) $display("FAIL noop_ready got=%b exp=1", sel_req_ready); else pass_cnt++;
        step();
        sel_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total_cnt++; if (switching !== 1'b0) $display("FAIL noop_switching[%0d] got=%b exp=0", k, switching); else pass_cnt++;
            total_cnt++; if (out_data !== 1'b1 || cur_sel !== 2'd0) $display("FAIL noop_data[%0d] got=%b/%0d exp=1/0", k, out_data, cur_sel); else pass_cnt++;
            step();
        end
    endtask

    task automatic test_switch_mid_frame();
        logic       e_out [0:7] = '{1, 1, 1, 1, 1, 0, 0, 0};
        logic       e_sw  [0:7] = '{1, 1, 1, 1, 1, 1, 0, 0};
        logic [1:0] e_cs  [0:7] = '{0, 0, 0, 0, 0, 0, 1, 1};
        wait_fc(3);
        sel_req = 2'd1; sel_req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            sel_req_valid = 1'b0;
            total_cnt++; if (out_data !== e_out[k]) $display("FAIL switch_out[%0d] got=%b exp=%b", k, out_data, e_out[k]); else pass_cnt++;
            total_cnt++; if (switching !== e_sw[k]) $display("FAIL switch_sw[%0d] got=%b exp=%b", k, switching, e_sw[k]); else pass_cnt++;
            total_cnt++; if (cur_sel !== e_cs[k]) $display("FAIL switch_sel[%0d] got=%0d exp=%0d", k, cur_sel, e_cs[k]); else pass_cnt++;
            total_cnt++; if (sel_req_ready !== ~e_sw[k]) $display("FAIL switch_ready[%0d] got=%b exp=%b", k, sel_req_ready, ~e_sw[k]); else pass_cnt++;
        end
    endtask

    task automatic test_accept_on_boundary();
        logic       e_out [0:11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        logic       e_sw  [0:11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        logic [1:0] e_cs  [0:11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2};
        wait_fc(7);
        sel_req = 2'd2; sel_req_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            sel_req_valid = 1'b0;
            total_cnt++; if (out_data !== e_out[k]) $display("FAIL bnd_out[%0d] got=%b exp=%b", k, out_data, e_out[k]); else pass_cnt++;
            total_cnt++; if (switching !== e_sw[k]) $display("FAIL bnd_sw[%0d] got=%b exp=%b", k, switching, e_sw[k]); else pass_cnt++;
            total_cnt++; if (cur_sel !== e_cs[k]) $display("FAIL bnd_sel[%0d] got=%0d exp=%0d", k, cur_sel, e_cs[k]); else pass_cnt++;
        end
    endtask

    task automatic test_out_of_range();
        sel_req3 = 2'd3; sel_req_valid3 = 1'b1;
        total_cnt++; if (sel_req_ready3 !== 1'b1) $display("FAIL oor_ready got=%b exp=1", sel_req_ready3); else pass_cnt++;
        step();
        sel_req_valid3 = 1'b0;
        total_cnt++; if (err3 !== 1'b1) $display("FAIL oor_err got=%b exp=1", err3); else pass_cnt++;
        total_cnt++; if (cur_sel3 !== 2'd0 || switching3 !== 1'b0) $display("FAIL oor_sel got=%0d/%b exp=0/0", cur_sel3, switching3); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL oor_main_err got=%b exp=0", err); else pass_cnt++;
        for (int k = 0; k < 10; k++) step();
        total_cnt++; if (err3 !== 1'b1) $display("FAIL oor_sticky got=%b exp=1", err3); else pass_cnt++;
        total_cnt++; if (cur_sel3 !== 2'd0 || out_data3 !== 1'b1) $display("FAIL oor_route got=%0d/%b exp=0/1", cur_sel3, out_data3); else pass_cnt++;
    endtask

    task automatic test_reset_during_blank();
        sel_req = 2'd3; sel_req_valid = 1'b1;
        step();
        sel_req_valid = 1'b0;
        wait_fc(0);
        step();
        total_cnt++; if (switching !== 1'b1 || out_data !== 1'b0) $display("FAIL blank_pre_rst got=%b/%b exp=1/0", switching, out_data); else pass_cnt++;
        #2 rst = 1'b1; in_valid = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0 || out_data !== 1'b0) $display("FAIL arst_out got=%b/%b exp=0/0", out_valid, out_data); else pass_cnt++;
        total_cnt++; if (cur_sel !== 2'd0 || switching !== 1'b0) $display("FAIL arst_state got=%0d/%b exp=0/0", cur_sel, switching); else pass_cnt++;
        total_cnt++; if (sel_req_ready !== 1'b1 || err3 !== 1'b0) $display("FAIL arst_ready_err got=%b/%b exp=1/0", sel_req_ready, err3); else pass_cnt++;
        step(); step();
        rst = 1'b0; in_valid = 1'b1; fc = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            total_cnt++; if (cur_sel !== 2'd0 || switching !== 1'b0 || out_data !== 1'b1)
                $display("FAIL post_rst[%0d] got=%0d/%b/%b exp=0/0/1", k, cur_sel, switching, out_data); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_noop_same_channel();
        test_switch_mid_frame();
        test_accept_on_boundary();
        test_out_of_range();
        test_reset_during_blank();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
